jtframe_romslot_cache: RTL and testbench

- ROM-slot responder: the memory end of the CPU wait/cen-gating interface.
- Receives the CPU-side ROM chip select and address, and returns `data_ok`. The CPU wait logic turns `data_ok` into its `rom_ok` input.
- Serves reads from a two-line, fully associative cache of 32-bit lines. On a miss it fetches the line over the SDRAM request/ack/dst/rdy handshake.
- Sits between the game CPU wait logic and the SDRAM arbiter, one instance per CPU ROM.

---
 rtl/jtframe_romslot_cache.sv | 139 +++++++++++++
 tb/tb_jtframe_romslot_cache.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_romslot_cache.sv
// jtframe_romslot_cache: ROM-slot responder with a two-line, fully associative
// cache of 32-bit lines, refilled over the SDRAM req/ack/dst/rdy handshake.
// Optional macro JTFRAME_ROMSLOT_PREFETCH_EN: after a demand fill of line L,
// fetch line L+1 into the other entry if it is not already cached.
module jtframe_romslot_cache #(
  parameter  int AW = 17,
  parameter  int DW = 8,
  localparam int OW = (DW == 16) ? 1 : 2,
  localparam int LW = AW - OW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          addr_ok,
  output logic [DW-1:0] dout,
  output logic          data_ok,
  output logic [LW-1:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          data_dst,
  input  logic          data_rdy,
  input  logic [31:0]   din
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]         r_valid;
  logic [1:0][LW-1:0] r_tag;
  logic [1:0][31:0]   r_data;
  logic               r_lru;      // entry to replace on the next demand fill
  logic [1:0]         r_st;
  logic               r_req;
  logic [LW-1:0]      r_addr;

  logic [LW-1:0] w_line;
  logic [OW-1:0] w_off;
  logic          w_m0, w_m1, w_hit;
  logic [31:0]   w_sel, w_word;
  logic [4:0]    w_shamt;
  logic          w_rsp, w_fill, w_way;

  assign w_line = addr[AW-1:OW];
  assign w_off  = addr[OW-1:0];
  assign w_m0   = r_valid[0] && (r_tag[0] == w_line);
  assign w_m1   = r_valid[1] && (r_tag[1] == w_line);
  assign w_hit  = addr_ok && (w_m0 || w_m1);

  // Little-endian word pick inside the selected line
  assign w_sel   = w_m1 ? r_data[1] : r_data[0];
  assign w_shamt = 5'(32'(w_off) * DW);
  assign w_word  = w_sel >> w_shamt;

  assign data_ok    = w_hit;
  assign dout       = w_hit ? w_word[DW-1:0] : '0;
  assign sdram_req  = r_req;
  assign sdram_addr = r_addr;

  // A response only counts once the request has been accepted (or in the same cycle)
  assign w_rsp  = data_dst && data_rdy;
  assign w_fill = w_rsp && ((r_st == ST_WAIT) || (r_st == ST_REQ && sdram_ack));

`ifdef JTFRAME_ROMSLOT_PREFETCH_EN
  logic          r_pf;            // current fetch is a prefetch
  logic          r_pf_way;        // entry not holding the demand line
  logic [LW-1:0] w_next;
  logic          w_next_have;

  assign w_way       = r_pf ? r_pf_way : r_lru;
  assign w_next      = r_addr + LW'(1);
  assign w_next_have = r_valid[!w_way] && (r_tag[!w_way] == w_next);
`else
  assign w_way = r_lru;
`endif

  // Cache array and replacement pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_tag   <= '0;
      r_data  <= '0;
      r_lru   <= 1'b0;
    end else begin
      if (w_hit) r_lru <= w_m0;   // point at the entry not just used
      if (w_fill) begin
        r_valid[w_way] <= 1'b1;
        r_tag[w_way]   <= r_addr;
        r_data[w_way]  <= din;
`ifdef JTFRAME_ROMSLOT_PREFETCH_EN
        if (!r_pf) r_lru <= !w_way;
`else
        r_lru <= !w_way;
`endif
      end
    end
  end

  // Fetch sequencer: one outstanding request, never aborted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= ST_IDLE;
      r_req  <= 1'b0;
      r_addr <= '0;
`ifdef JTFRAME_ROMSLOT_PREFETCH_EN
      r_pf     <= 1'b0;
      r_pf_way <= 1'b0;
`endif
    end else begin
      case (r_st)
        ST_IDLE: if (addr_ok && !w_hit) begin
          r_addr <= w_line;
          r_req  <= 1'b1;
          r_st   <= ST_REQ;
        end
        ST_REQ: if (sdram_ack) begin
          r_req <= 1'b0;
          r_st  <= ST_WAIT;
        end
        default: ;
      endcase
      if (w_fill) begin
        r_st <= ST_IDLE;
`ifdef JTFRAME_ROMSLOT_PREFETCH_EN
        if (!r_pf && !w_next_have) begin
          r_st     <= ST_REQ;
          r_req    <= 1'b1;
          r_addr   <= w_next;
          r_pf     <= 1'b1;
          r_pf_way <= !w_way;
        end else begin
          r_pf <= 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_jtframe_romslot_cache.sv
// Directed bench for jtframe_romslot_cache (AW=17, DW=8, default build).
module tb_jtframe_romslot_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] addr;
  logic        addr_ok;
  logic [7:0]  dout;
  logic        data_ok;
  logic [14:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        data_dst;
  logic        data_rdy;
  logic [31:0] din;

  int n_chk = 0;
  int n_err = 0;
  int n_req = 0;
  logic req_q = 1'b0;

  jtframe_romslot_cache #(.AW(17), .DW(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .addr_ok(addr_ok), .dout(dout),
    .data_ok(data_ok), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .data_dst(data_dst), .data_rdy(data_rdy), .din(din)
  );

  always #5 clk = ~clk;

  // count request pulses
  always @(posedge clk) begin
    req_q <= sdram_req;
    if (sdram_req && !req_q) n_req++;
  end

  typedef struct {
    logic [16:0] a;
    logic        cs;
    logic        exp_ok;
    logic [7:0]  exp_dout;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request, check its line, ack after dly cycles, deliver data.
  task automatic fetch(input logic [14:0] line, input logic [31:0] data, input int dly, input bit same);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sdram_req) begin got = 1'b1; break; end
      tick();
    end
    check("req_seen", 32'(got), 32'd1);
    if (!got) return;
    check("req_addr", 32'(sdram_addr), 32'(line));
    repeat (dly) tick();
    check("req_hold", 32'(sdram_req), 32'd1);
    check("req_addr_hold", 32'(sdram_addr), 32'(line));
    sdram_ack = 1'b1;
    if (same) begin data_dst = 1'b1; data_rdy = 1'b1; din = data; end
    tick();
    sdram_ack = 1'b0; data_dst = 1'b0; data_rdy = 1'b0;
    check("req_drop", 32'(sdram_req), 32'd0);
    if (!same) begin
      tick();
      data_dst = 1'b1; data_rdy = 1'b1; din = data;
      #1 check("ok_before_fill", 32'(data_ok), 32'd0);
      tick();
      data_dst = 1'b0; data_rdy = 1'b0;
    end
    #1;
  endtask

  initial begin
    int n0;
    bit got;
    rst = 1'b1; addr = '0; addr_ok = 1'b0; sdram_ack = 1'b0;
    data_dst = 1'b0; data_rdy = 1'b0; din = '0;
    tbl[0] = '{17'h00004, 1'b1, 1'b1, 8'h11};
    tbl[1] = '{17'h00005, 1'b1, 1'b1, 8'h22};
    tbl[2] = '{17'h00006, 1'b1, 1'b1, 8'h33};
    tbl[3] = '{17'h00007, 1'b1, 1'b1, 8'h44};
    tbl[4] = '{17'h00004, 1'b0, 1'b0, 8'h00};
    tbl[5] = '{17'h00008, 1'b0, 1'b0, 8'h00};

    // reset state
    tick(); tick();
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_saddr", 32'(sdram_addr), 32'd0);
    check("rst_ok", 32'(data_ok), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    tick();

    // first miss: line 1, ack after 3 cycles
    addr = 17'h00005; addr_ok = 1'b1;
    #1 check("miss_ok", 32'(data_ok), 32'd0);
    fetch(15'h0001, 32'h44332211, 3, 1'b0);
    check("fill_ok", 32'(data_ok), 32'd1);
    check("fill_dout", 32'(dout), 32'h22);

    // hits on the same line, no request
    foreach (tbl[i]) begin
      addr = tbl[i].a; addr_ok = tbl[i].cs;
      #1;
      check($sformatf("tbl%0d_ok", i), 32'(data_ok), 32'(tbl[i].exp_ok));
      if (tbl[i].exp_ok) check($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].exp_dout));
      tick();
      check($sformatf("tbl%0d_req", i), 32'(sdram_req), 32'd0);
    end

    // LRU: fill B, touch A, miss C -> C replaces B
    addr = 17'h00040; addr_ok = 1'b1;
    fetch(15'h0010, 32'h5B6B7B8B, 0, 1'b0);
    check("B_dout", 32'(dout), 32'h8B);
    addr = 17'h00004; tick();
    addr = 17'h00080;
    fetch(15'h0020, 32'hC3C2C1C0, 1, 1'b0);
    check("C_dout", 32'(dout), 32'hC0);
    addr = 17'h00006;
    #1 check("A_hit", 32'(data_ok), 32'd1);
    check("A_dout", 32'(dout), 32'h33);
    tick();
    addr = 17'h00041;
    #1 check("B_evicted", 32'(data_ok), 32'd0);
    tick();
    check("B_req", 32'(sdram_req), 32'd1);
    check("B_req_addr", 32'(sdram_addr), 32'h10);
    // response before ack is ignored
    data_dst = 1'b1; data_rdy = 1'b1; din = 32'hDEADBEEF;
    tick();
    data_dst = 1'b0; data_rdy = 1'b0;
    check("early_rsp_req", 32'(sdram_req), 32'd1);
    check("early_rsp_ok", 32'(data_ok), 32'd0);
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    // data_rdy without data_dst is ignored
    data_rdy = 1'b1; din = 32'hDEADBEEF;
    tick();
    data_rdy = 1'b0;
    check("rdy_nodst_ok", 32'(data_ok), 32'd0);
    data_dst = 1'b1; data_rdy = 1'b1; din = 32'h5B6B7B8B;
    tick();
    data_dst = 1'b0; data_rdy = 1'b0;
    check("B_refill_ok", 32'(data_ok), 32'd1);
    check("B_refill_dout", 32'(dout), 32'h7B);

    // ack + response in the REQ cycle: one pulse, back to IDLE
    n0 = n_req;
    addr = 17'h000C0;
    fetch(15'h0030, 32'hDDCCBBAA, 0, 1'b1);
    check("same_ok", 32'(data_ok), 32'd1);
    check("same_dout", 32'(dout), 32'hAA);
    repeat (3) tick();
    check("same_req_low", 32'(sdram_req), 32'd0);
    check("same_pulses", 32'(n_req - n0), 32'd1);
    addr = 17'h000C4;
    tick();
    check("idle_next_req", 32'(sdram_req), 32'd1);
    fetch(15'h0031, 32'h01020304, 0, 1'b0);
    check("idle_next_dout", 32'(dout), 32'h04);

    // all-ones line caches normally, no aliasing with line 0
    addr = 17'h1FFFF;
    fetch(15'h7FFF, 32'h87654321, 1, 1'b0);
    check("top_ok", 32'(data_ok), 32'd1);
    check("top_dout", 32'(dout), 32'h87);
    addr = 17'h1FFFC;
    #1 check("top_dout0", 32'(dout), 32'h21);
    addr = 17'h00003;
    #1 check("line0_miss", 32'(data_ok), 32'd0);
    addr_ok = 1'b0;
    tick();

    // reset during WAIT, stale response afterwards
    addr = 17'h00100; addr_ok = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sdram_req) begin got = 1'b1; break; end
      tick();
    end
    check("rstw_req", 32'(got), 32'd1);
    sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("rstw_req_clr", 32'(sdram_req), 32'd0);
    check("rstw_saddr_clr", 32'(sdram_addr), 32'd0);
    check("rstw_ok", 32'(data_ok), 32'd0);
    check("rstw_dout", 32'(dout), 32'd0);
    tick(); tick();
    addr_ok = 1'b0; rst = 1'b0;
    tick();
    data_dst = 1'b1; data_rdy = 1'b1; din = 32'hA5A5A5A5;
    tick();
    data_dst = 1'b0; data_rdy = 1'b0;
    check("stale_req", 32'(sdram_req), 32'd0);
    addr_ok = 1'b1;
    #1 check("stale_ok", 32'(data_ok), 32'd0);
    addr = 17'h00004;
    #1 check("post_rst_A_miss", 32'(data_ok), 32'd0);
    tick();
    check("post_rst_req", 32'(sdram_req), 32'd1);
    check("post_rst_saddr", 32'(sdram_addr), 32'h1);
    fetch(15'h0001, 32'h44332211, 0, 1'b0);
    check("post_rst_dout", 32'(dout), 32'h11);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
